packet_tx: RTL and testbench

PACKET_TX -- requirements
Module: packet_tx

---
 rtl/eth_sniffer_pkg.sv | 19 +
 rtl/tx_timer.sv | 27 ++
 rtl/packet_tx.sv | 199 +++++++++++++++++++
 tb/tb_packet_tx.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_sniffer_pkg.sv
// Shared types and constants for the sniffer transmit path.
package eth_sniffer_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_ABORT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4
  } tx_state_t;

  // Unused byte lanes in the final word for a given length remainder.
  function automatic logic [1:0] tail_empty(input logic [1:0] len_lsb);
    return 2'(3'd4 - {1'b0, len_lsb});
  endfunction

endpackage

// File: rtl/tx_timer.sv
// Loadable down counter with zero flag; backs both the gap and underrun timers.
module tx_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/packet_tx.sv
// Frame transmitter: streams words from a show-ahead FIFO with sop/eop framing,
// underrun abort, drain and inter-frame gap. Optional counters: PACKET_TX_STATS_EN.
module packet_tx
  import eth_sniffer_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_WIDTH      = 11,
  parameter int IFG_CYCLES     = 3,
  parameter int UNDERRUN_LIMIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  output logic                  busy,
  output logic                  done,
  output logic                  done_err,
  input  logic                  rdempty,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  output logic                  rdreq,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_sop,
  output logic                  tx_eop,
  output logic [1:0]            tx_empty,
  output logic                  tx_error
`ifdef PACKET_TX_STATS_EN
 ,output logic [63:0]           frames_sent,
  output logic [63:0]           frames_aborted
`endif
);

  localparam int CNT_W      = LEN_WIDTH - 1;
  localparam int TMR_W      = (CNT_W > 16) ? CNT_W : 16;
  localparam int WORD_SHIFT = $clog2(BYTES_PER_WORD);
  localparam tx_state_t END_ST = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam logic [TMR_W-1:0] UR_LOAD  = TMR_W'((UNDERRUN_LIMIT > 0) ? UNDERRUN_LIMIT - 1 : 0);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] words_q;
  logic [CNT_W-1:0] sent_q;
  logic [1:0]       empty_q;
  logic             done_q, done_err_q;

  logic [CNT_W-1:0] len_words;
  logic             accept;
  logic             last_word;
  logic             set_done, set_err;
  logic             ur_load, ur_dec, ur_zero;
  logic             gap_load, gap_dec, gap_zero;

  assign len_words = CNT_W'(frame_len >> WORD_SHIFT) + CNT_W'(|frame_len[WORD_SHIFT-1:0]);
  assign last_word = ((sent_q + CNT_W'(1)) == words_q);

  tx_timer #(.WIDTH(TMR_W)) u_underrun (
    .clk      (clk),
    .rst      (rst),
    .load     (ur_load),
    .load_val (UR_LOAD),
    .dec      (ur_dec),
    .zero     (ur_zero)
  );

  tx_timer #(.WIDTH(TMR_W)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    tx_sop   = 1'b0;
    tx_eop   = 1'b0;
    tx_empty = 2'd0;
    tx_error = 1'b0;
    rdreq    = 1'b0;
    set_done = 1'b0;
    set_err  = 1'b0;
    ur_load  = 1'b0;
    ur_dec   = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (frame_len != '0)) begin
          accept  = 1'b1;
          ur_load = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_valid = ~rdempty;
        tx_data  = fifo_q;
        tx_sop   = (sent_q == '0);
        tx_eop   = last_word;
        tx_empty = last_word ? empty_q : 2'd0;
        rdreq    = tx_valid & tx_ready;
        if (rdreq) begin
          ur_load = 1'b1;
          if (last_word) begin
            set_done = 1'b1;
            gap_load = 1'b1;
            state_d  = END_ST;
          end
        end else if (rdempty) begin
          // Zero flag means this is the LIMIT-th consecutive empty cycle.
          if (ur_zero) begin
            state_d = ST_ABORT;
          end else begin
            ur_dec = 1'b1;
          end
        end
      end
      ST_ABORT: begin
        tx_valid = 1'b1;
        tx_sop   = (sent_q == '0);
        tx_eop   = 1'b1;
        tx_error = 1'b1;
        if (tx_ready) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Discard the rest of the frame the writer still owes us.
        rdreq = ~rdempty;
        if (rdreq && last_word) begin
          set_done = 1'b1;
          set_err  = 1'b1;
          gap_load = 1'b1;
          state_d  = END_ST;
        end
      end
      ST_GAP: begin
        if (gap_zero) begin
          state_d = ST_IDLE;
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_q    <= '0;
      sent_q     <= '0;
      empty_q    <= 2'd0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      done_q     <= set_done;
      done_err_q <= set_err;
      if (accept) begin
        words_q <= len_words;
        empty_q <= tail_empty(frame_len[1:0]);
        sent_q  <= '0;
      end else if (rdreq) begin
        sent_q <= sent_q + CNT_W'(1);
      end
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign done_err = done_err_q;

`ifdef PACKET_TX_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frames_sent    <= '0;
      frames_aborted <= '0;
    end else if (done_q) begin
      if (done_err_q) begin
        frames_aborted <= frames_aborted + 64'd1;
      end else begin
        frames_sent <= frames_sent + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_packet_tx.sv
// Directed bench for packet_tx with a show-ahead FIFO model driven from the stimulus thread.
module tb_packet_tx;

  localparam int DW = 32;
  localparam int LW = 11;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic        err;
    logic [1:0]  emp;
  } beat_t;

  typedef struct {
    int   cyc;
    logic err;
  } done_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [LW-1:0] frame_len;
  logic          busy, done, done_err;
  logic          rdempty;
  logic [DW-1:0] fifo_q;
  logic          rdreq;
  logic          tx_ready;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_sop, tx_eop, tx_error;
  logic [1:0]    tx_empty;
`ifdef PACKET_TX_STATS_EN
  logic [63:0]   frames_sent, frames_aborted;
`endif

  logic [DW-1:0] fifo[$];
  beat_t         beats[$];
  done_t         dones[$];
  logic          busy_log[$];
  int            pops;
  int            cyc_cnt;
  int            checks;
  int            errors;

  packet_tx #(
    .DATA_WIDTH     (DW),
    .LEN_WIDTH      (LW),
    .IFG_CYCLES     (3),
    .UNDERRUN_LIMIT (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frame_len (frame_len),
    .busy      (busy),
    .done      (done),
    .done_err  (done_err),
    .rdempty   (rdempty),
    .fifo_q    (fifo_q),
    .rdreq     (rdreq),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_sop    (tx_sop),
    .tx_eop    (tx_eop),
    .tx_empty  (tx_empty),
    .tx_error  (tx_error)
`ifdef PACKET_TX_STATS_EN
   ,.frames_sent    (frames_sent),
    .frames_aborted (frames_aborted)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic refresh();
    rdempty = (fifo.size() == 0);
    fifo_q  = rdempty ? '0 : fifo[0];
  endtask

  task automatic clear_log();
    beats.delete();
    dones.delete();
    busy_log.delete();
    pops    = 0;
    cyc_cnt = 0;
  endtask

  // Called at the falling edge: log this cycle, then step to just after the rising edge.
  task automatic next_cycle();
    logic pop;
    pop = rdreq;
    if (tx_valid && tx_ready) beats.push_back('{cyc_cnt, tx_data, tx_sop, tx_eop, tx_error, tx_empty});
    if (done) dones.push_back('{cyc_cnt, done_err});
    if (rdreq) pops++;
    busy_log.push_back(busy);
    @(posedge clk);
    #1;
    if (pop && fifo.size() > 0) void'(fifo.pop_front());
    refresh();
    cyc_cnt++;
  endtask

  task automatic cyc();
    @(negedge clk);
    next_cycle();
  endtask

  task automatic launch(input logic [LW-1:0] len);
    start     = 1'b1;
    frame_len = len;
    @(negedge clk);
    next_cycle();
    start     = 1'b0;
    frame_len = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, done_err, rdreq, tx_valid, tx_sop, tx_eop, tx_error, tx_empty} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0", {busy, done, done_err, rdreq, tx_valid, tx_sop, tx_eop, tx_error, tx_empty});
    end
    checks++;
    if (tx_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", tx_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] exp_d[3];
    logic [4:0]  exp_f[3];
    exp_d = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003};
    exp_f = '{5'b10_0_00, 5'b00_0_00, 5'b01_0_11};
    clear_log();
    fifo = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003};
    refresh();
    tx_ready = 1'b1;
    launch(11'd9);
    repeat (10) cyc();
    checks++;
    if (beats.size() != 3) begin
      errors++;
      $display("FAIL basic_beats: got %0d expected 3", beats.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (beats[i].data !== exp_d[i] || beats[i].cyc != i + 1) begin
          errors++;
          $display("FAIL basic_word%0d: got %h@%0d expected %h@%0d", i, beats[i].data, beats[i].cyc, exp_d[i], i + 1);
        end
        checks++;
        if ({beats[i].sop, beats[i].eop, beats[i].err, beats[i].emp} !== exp_f[i]) begin
          errors++;
          $display("FAIL basic_flags%0d: got %b expected %b", i, {beats[i].sop, beats[i].eop, beats[i].err, beats[i].emp}, exp_f[i]);
        end
      end
    end
    checks++;
    if (dones.size() != 1 || dones[0].cyc != 4 || dones[0].err !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got n=%0d cyc=%0d err=%b expected n=1 cyc=4 err=0", dones.size(), dones[0].cyc, dones[0].err);
    end
    checks++;
    if (busy_log[6] !== 1'b1 || busy_log[7] !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: got %b%b expected 10", busy_log[6], busy_log[7]);
    end
    checks++;
    if (pops != 3) begin
      errors++;
      $display("FAIL basic_pops: got %0d expected 3", pops);
    end
  endtask

  task automatic test_hold();
    clear_log();
    fifo = '{32'hD00D_F00D};
    refresh();
    tx_ready = 1'b0;
    launch(11'd4);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if ({tx_valid, tx_sop, tx_eop, tx_empty, rdreq} !== 6'b111_00_0 || tx_data !== 32'hD00D_F00D) begin
        errors++;
        $display("FAIL hold_cyc%0d: got %b %h expected 111000 d00df00d", i, {tx_valid, tx_sop, tx_eop, tx_empty, rdreq}, tx_data);
      end
      next_cycle();
    end
    tx_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rdreq !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: got rdreq=%b expected 1", rdreq);
    end
    next_cycle();
    repeat (6) cyc();
    checks++;
    if (pops != 1 || beats.size() != 1) begin
      errors++;
      $display("FAIL hold_count: got pops=%0d beats=%0d expected 1 1", pops, beats.size());
    end
    checks++;
    if (dones.size() != 1 || dones[0].err !== 1'b0) begin
      errors++;
      $display("FAIL hold_done: got n=%0d err=%b expected 1 0", dones.size(), dones[0].err);
    end
  endtask

  task automatic test_underrun();
    clear_log();
    fifo = '{32'h0000_00E1, 32'h0000_00E2};
    refresh();
    tx_ready = 1'b1;
    launch(11'd16);
    repeat (18) cyc();
    @(negedge clk);
    checks++;
    if (beats.size() != 2) begin
      errors++;
      $display("FAIL ur_early: got %0d beats before abort expected 2", beats.size());
    end
    checks++;
    if ({tx_valid, tx_sop, tx_eop, tx_error, rdreq} !== 5'b1_0_1_1_0 || tx_data !== '0) begin
      errors++;
      $display("FAIL ur_abort_word: got %b %h expected 10110 0", {tx_valid, tx_sop, tx_eop, tx_error, rdreq}, tx_data);
    end
    next_cycle();
    repeat (2) cyc();
    fifo.push_back(32'h0000_00E3);
    fifo.push_back(32'h0000_00E4);
    refresh();
    @(negedge clk);
    checks++;
    if (rdreq !== 1'b1 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL ur_drain: got rdreq=%b valid=%b expected 1 0", rdreq, tx_valid);
    end
    next_cycle();
    repeat (8) cyc();
    checks++;
    if (dones.size() != 1 || dones[0].cyc != 24 || dones[0].err !== 1'b1) begin
      errors++;
      $display("FAIL ur_done: got n=%0d cyc=%0d err=%b expected 1 24 1", dones.size(), dones[0].cyc, dones[0].err);
    end
    checks++;
    if (pops != 4 || fifo.size() != 0 || beats.size() != 3) begin
      errors++;
      $display("FAIL ur_counts: got pops=%0d fifo=%0d beats=%0d expected 4 0 3", pops, fifo.size(), beats.size());
    end
`ifdef PACKET_TX_STATS_EN
    checks++;
    if (frames_sent !== 64'd1 || frames_aborted !== 64'd1) begin
      errors++;
      $display("FAIL stats: got sent=%0d aborted=%0d expected 1 1", frames_sent, frames_aborted);
    end
`endif
  endtask

  task automatic test_ignore();
    logic any_busy;
    clear_log();
    fifo = '{32'h0000_0AAA};
    refresh();
    tx_ready = 1'b1;
    launch(11'd4);
    cyc();
    fifo.push_back(32'h0000_0BBB);
    fifo.push_back(32'h0000_0CCC);
    refresh();
    start     = 1'b1;
    frame_len = 11'd8;
    repeat (3) cyc();
    start     = 1'b0;
    frame_len = '0;
    repeat (8) cyc();
    checks++;
    if (beats.size() != 1 || dones.size() != 1 || pops != 1) begin
      errors++;
      $display("FAIL ign_gap: got beats=%0d dones=%0d pops=%0d expected 1 1 1", beats.size(), dones.size(), pops);
    end
    checks++;
    if (busy_log[5] !== 1'b0) begin
      errors++;
      $display("FAIL ign_gap_busy: got %b expected 0", busy_log[5]);
    end
    clear_log();
    launch(11'd0);
    repeat (5) cyc();
    any_busy = 1'b0;
    foreach (busy_log[i]) any_busy |= busy_log[i];
    checks++;
    if (beats.size() != 0 || dones.size() != 0 || pops != 0 || any_busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_zero_len: got beats=%0d dones=%0d pops=%0d busy=%b expected 0 0 0 0", beats.size(), dones.size(), pops, any_busy);
    end
    fifo.delete();
    refresh();
  endtask

  task automatic test_reset_mid();
    clear_log();
    fifo = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
    refresh();
    tx_ready = 1'b1;
    launch(11'd20);
    cyc();
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_sop !== 1'b0 || tx_data !== 32'h2) begin
      errors++;
      $display("FAIL rstmid_pre: got valid=%b sop=%b data=%h expected 1 0 2", tx_valid, tx_sop, tx_data);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, done_err, rdreq, tx_valid, tx_sop, tx_eop, tx_error, tx_empty} !== 10'b0 || tx_data !== '0) begin
      errors++;
      $display("FAIL rstmid_async: got %b %h expected 0 0", {busy, done, done_err, rdreq, tx_valid, tx_sop, tx_eop, tx_error, tx_empty}, tx_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (dones.size() != 0) begin
      errors++;
      $display("FAIL rstmid_nodone: got %0d expected 0", dones.size());
    end
    fifo.delete();
    fifo.push_back(32'h5A5A_5A5A);
    refresh();
    clear_log();
    launch(11'd4);
    repeat (6) cyc();
    checks++;
    if (beats.size() != 1) begin
      errors++;
      $display("FAIL rstmid_beats: got %0d expected 1", beats.size());
    end else begin
      checks++;
      if ({beats[0].sop, beats[0].eop, beats[0].err} !== 3'b110 || beats[0].data !== 32'h5A5A_5A5A) begin
        errors++;
        $display("FAIL rstmid_frame: got %b %h expected 110 5a5a5a5a", {beats[0].sop, beats[0].eop, beats[0].err}, beats[0].data);
      end
    end
    checks++;
    if (dones.size() != 1 || dones[0].err !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_done: got n=%0d err=%b expected 1 0", dones.size(), dones[0].err);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    frame_len = '0;
    tx_ready  = 1'b0;
    fifo.delete();
    refresh();
    clear_log();
    test_reset();
    test_basic();
    test_underrun();
    test_hold();
    test_ignore();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
